// File: rtl/antirebotes.sv
// -----------------------------------------------------------------------------
// antirebotes -- push-button debouncer
//
// Purpose:
//   Filters a bouncing mechanical push-button level into a clean, registered
//   level. A new level is accepted only after STABLE_CYCLES consecutive clock
//   samples at that level. Any single opposite sample during qualification
//   aborts it and returns the FSM to the previous stable state.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a new level (2..2^24)
//
// Ports:
//   clk       input   single clock, all state updates on its rising edge
//   rst_n     input   asynchronous active-low reset
//   button_i  input   raw (bouncing) button level
//   button_o  output  debounced level, flip-flop output synchronous to clk
//
// Configuration macro:
//   ANTIREBOTES_SYNC_EN  when defined, button_i passes through a 2-flop
//                        synchronizer (reset value 0) before the FSM, adding
//                        two cycles of latency. When undefined, button_i is
//                        used directly and must already be synchronous to clk.
// -----------------------------------------------------------------------------
module antirebotes #(
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic button_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);

  // The output level equals state bit 1 so the decode stays trivial.
  typedef enum logic [1:0] {
    ST_LOW      = 2'b00,
    ST_CHK_HIGH = 2'b01,
    ST_HIGH     = 2'b11,
    ST_CHK_LOW  = 2'b10
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             button_q;
  logic             button_d;
  logic             sample_s;

`ifdef ANTIREBOTES_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample_s = sync2_q;
`else
  assign sample_s = button_i;
`endif

  // Next-state and counter logic of the qualification FSM.
  always_comb begin
    state_d = ST_LOW;
    cnt_d   = CNT_ZERO;
    case (state_q)
      ST_LOW: begin
        if (sample_s) begin
          state_d = ST_CHK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_CHK_HIGH: begin
        if (!sample_s) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_MAX) begin
          // >= rather than == so a corrupted count can never run past the
          // limit or wrap; it simply completes the qualification.
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_CHK_HIGH;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sample_s) begin
          state_d = ST_CHK_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_CHK_LOW: begin
        if (sample_s) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_CHK_LOW;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Any unexpected encoding recovers to a known idle state.
        state_d = ST_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state, so the registered output changes on
  // the same edge the FSM enters HIGH or LOW.
  always_comb begin
    button_d = 1'b0;
    if ((state_d == ST_HIGH) || (state_d == ST_CHK_LOW)) begin
      button_d = 1'b1;
    end else begin
      button_d = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOW;
      cnt_q    <= CNT_ZERO;
      button_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      button_q <= button_d;
    end
  end

  assign button_o = button_q;

endmodule

// File: tb/tb_antirebotes.sv
// -----------------------------------------------------------------------------
// tb_antirebotes -- self-checking bench for antirebotes
//
// Two instances share one input: dut_a with STABLE_CYCLES=4 and dut_b with
// STABLE_CYCLES=2. A run-length reference model (consecutive samples differing
// from the accepted level) predicts both outputs on every edge, and directed
// scenarios check hand-derived expectations. Works with or without
// ANTIREBOTES_SYNC_EN defined.
// -----------------------------------------------------------------------------
module tb_antirebotes;

  localparam int N_A = 4;
  localparam int N_B = 2;
`ifdef ANTIREBOTES_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic button_i = 1'b0;
  logic out_a;
  logic out_b;

  int n_checks = 0;
  int n_fail   = 0;

  antirebotes #(.STABLE_CYCLES(N_A)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i),
    .button_o (out_a)
  );

  antirebotes #(.STABLE_CYCLES(N_B)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i),
    .button_o (out_b)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_n[2]    = '{N_A, N_B};
  bit m_acc[2]  = '{1'b0, 1'b0};
  int m_run[2]  = '{0, 0};
  bit m_h1      = 1'b0;
  bit m_h2      = 1'b0;
  bit m_s       = 1'b0;
  bit m_obs[2]  = '{1'b0, 1'b0};
  bit m_prev[2] = '{1'b0, 1'b0};
  int m_last[2] = '{-100000, -100000};
  int cyc       = 0;

  // Scoreboard: accepted level flips once a run of N samples differs from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc  = '{1'b0, 1'b0};
      m_run  = '{0, 0};
      m_h1   = 1'b0;
      m_h2   = 1'b0;
      m_prev = '{1'b0, 1'b0};
      m_last = '{-100000, -100000};
    end else begin
      cyc++;
`ifdef ANTIREBOTES_SYNC_EN
      m_s  = m_h2;
      m_h2 = m_h1;
      m_h1 = button_i;
`else
      m_s  = button_i;
`endif
      for (int i = 0; i < 2; i++) begin
        if (m_s != m_acc[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == m_n[i]) begin
          m_acc[i] = m_s;
          m_run[i] = 0;
        end
      end
      #1;
      m_obs[0] = out_a;
      m_obs[1] = out_b;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (m_obs[i] !== m_acc[i]) begin
          n_fail++;
          $display("FAIL model_%0d cyc=%0d: got %0b expected %0b", i, cyc, m_obs[i], m_acc[i]);
        end
        if (m_obs[i] != m_prev[i]) begin
          n_checks++;
          if (cyc - m_last[i] < m_n[i]) begin
            n_fail++;
            $display("FAIL spacing_%0d cyc=%0d: got gap %0d expected >= %0d", i, cyc, cyc - m_last[i], m_n[i]);
          end
          m_last[i] = cyc;
          m_prev[i] = m_obs[i];
        end
      end
    end
  end

  // Drive a level before the next edge and return 2 time units after it.
  task automatic step(input bit b);
    button_i = b;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (out_a !== 1'b0) begin n_fail++; $display("FAIL reset_a: got %0b expected 0", out_a); end
    n_checks++;
    if (out_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got %0b expected 0", out_b); end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    repeat (12) step(1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      n_checks++;
      if (out_a !== bit'(k >= N_A - 1 + SYNC_LAT)) begin
        n_fail++;
        $display("FAIL press_a k=%0d: got %0b expected %0b", k, out_a, k >= N_A - 1 + SYNC_LAT);
      end
      n_checks++;
      if (out_b !== bit'(k >= N_B - 1 + SYNC_LAT)) begin
        n_fail++;
        $display("FAIL press_b k=%0d: got %0b expected %0b", k, out_b, k >= N_B - 1 + SYNC_LAT);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[16];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    repeat (12) step(1'b0);
    for (int k = 0; k < 16; k++) begin
      step(pat[k]);
      // a: highs at 5..8 are the first run of 4; b: highs at 2,3 qualify.
      n_checks++;
      if (out_a !== bit'(k >= 8 + SYNC_LAT)) begin
        n_fail++;
        $display("FAIL bounce_a k=%0d: got %0b expected %0b", k, out_a, k >= 8 + SYNC_LAT);
      end
      n_checks++;
      if (out_b !== bit'(k >= 3 + SYNC_LAT)) begin
        n_fail++;
        $display("FAIL bounce_b k=%0d: got %0b expected %0b", k, out_b, k >= 3 + SYNC_LAT);
      end
    end
  endtask

  task automatic test_release_glitch();
    repeat (6) step(1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 13; k++) begin
        step((k < 3) ? 1'b0 : 1'b1);
        n_checks++;
        if (out_a !== 1'b1) begin
          n_fail++;
          $display("FAIL glitch_a r=%0d k=%0d: got %0b expected 1", r, k, out_a);
        end
      end
    end
  endtask

  task automatic test_reset_mid_check();
    repeat (12) step(1'b0);
    for (int k = 0; k < 3 + SYNC_LAT; k++) step(1'b1);
    n_checks++;
    if (out_a !== 1'b0) begin n_fail++; $display("FAIL midchk_pre_a: got %0b expected 0", out_a); end
    #4;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_a !== 1'b0) begin n_fail++; $display("FAIL midchk_async_a: got %0b expected 0", out_a); end
    n_checks++;
    if (out_b !== 1'b0) begin n_fail++; $display("FAIL midchk_async_b: got %0b expected 0", out_b); end
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      n_checks++;
      if (out_a !== bit'(k >= N_A - 1 + SYNC_LAT)) begin
        n_fail++;
        $display("FAIL midchk_a k=%0d: got %0b expected %0b", k, out_a, k >= N_A - 1 + SYNC_LAT);
      end
      n_checks++;
      if (out_b !== bit'(k >= N_B - 1 + SYNC_LAT)) begin
        n_fail++;
        $display("FAIL midchk_b k=%0d: got %0b expected %0b", k, out_b, k >= N_B - 1 + SYNC_LAT);
      end
    end
  endtask

  task automatic test_boundary();
    int j;
    bit exp_b;
    repeat (12) step(1'b0);
    for (int k = 0; k < 20; k++) begin
      step(bit'(k % 2 == 0));
      n_checks++;
      if (out_b !== 1'b0) begin n_fail++; $display("FAIL alt_b k=%0d: got %0b expected 0", k, out_b); end
      n_checks++;
      if (out_a !== 1'b0) begin n_fail++; $display("FAIL alt_a k=%0d: got %0b expected 0", k, out_a); end
    end
    repeat (6) step(1'b0);
    for (int k = 0; k < 24; k++) begin
      step(bit'((k / 2) % 2 == 0));
      j = k - (N_B - 1) - SYNC_LAT;
      exp_b = (j >= 0) ? bit'((j / 2) % 2 == 0) : 1'b0;
      n_checks++;
      if (out_b !== exp_b) begin
        n_fail++;
        $display("FAIL hold2_b k=%0d: got %0b expected %0b", k, out_b, exp_b);
      end
      n_checks++;
      if (out_a !== 1'b0) begin n_fail++; $display("FAIL hold2_a k=%0d: got %0b expected 0", k, out_a); end
    end
  endtask

  task automatic test_stress();
    bit lvl;
    int blen;
    for (int r = 0; r < 40; r++) begin
      lvl = 1'($urandom_range(0, 1));
      repeat (10) step(lvl);
      blen = int'($urandom_range(0, 3));
      for (int b = 0; b < blen; b++) step(1'($urandom_range(0, 1)));
    end
    repeat (10) step(1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid_check();
    test_boundary();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
